uart_rx: RTL

Serial 8N1 UART receiver, the receiving counterpart of `uart_tx`. It takes the serial line from the base station on a GPIO pin and returns bytes to the drive/SoC logic through a `valid`/`ready` holding register. The block runs on the 50 MHz system clock and samples at mid-bit using a per-bit divide counter. It flags framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a valid/ready holding register.
// Ports: clk, reset_n, uart_in in; data_rx/valid (ready in), frame_err, overrun, busy out.
module uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_in,
   output logic [7:0] data_rx,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_baud
         $error("uart_rx: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          rx_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          good_q, good_d;
   logic          ferr_q, ferr_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          busy_q, busy_d;
   logic          tick;

   assign rx_s = sync2_q;
   assign tick = (cnt_q == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         good_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         good_q  <= good_d;
         ferr_q  <= ferr_d;
      end
   end

   // Frame sequencer; good_d/ferr_d mark the stop-bit sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      good_d  = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = HALF;
            end
         end
         START: begin
            if (!tick) begin
               cnt_d = cnt_q - ONE;
            end else if (!rx_s) begin
               state_d = DATA;
               idx_d   = 3'd0;
               cnt_d   = FULL;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - ONE;
            end else begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = FULL;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - ONE;
            end else if (rx_s) begin
               good_d  = 1'b1;
               state_d = IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            // Hold off until the line is released so a break is one event.
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding register: a commit may coincide with the consumer's accept.
   always_comb begin
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = ferr_q;
      overrun_d   = 1'b0;
      busy_d      = (state_q != IDLE);
      if (good_q) begin
         if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign data_rx   = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule
